// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: FSM states and the
// bundle of pipeline-register control signals it drives.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  // Canned control patterns, field order as in ctrl_t
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_LOAD   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes and data-memory freezes, plus saturating stall/flush counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int unsigned LCNT_W = 3;

  state_e            state_q, state_d, saved_q, saved_d, eff_state;
  logic [LCNT_W-1:0] cnt_q, cnt_d;
  ctrl_t             ctrl;
  logic              freeze, lu_hazard, flush_evt;

  assign freeze    = mem_req && !mem_ready;
  assign lu_hazard = ID_EX_MemRead && (ID_EX_rd != REG_X0) &&
                     ((ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                      (ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leaving MEM_WAIT behaves exactly like the state that was interrupted
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    ctrl      = CTRL_RUN;
    flush_evt = 1'b0;
    eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    if (freeze) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      saved_d = eff_state;
    end else begin
      state_d = eff_state;
      case (eff_state)
        LOAD_STALL: begin
          ctrl = CTRL_LOAD;
          if (cnt_q == LCNT_W'(1)) begin
            state_d = RUN;
          end
          cnt_d = cnt_q - LCNT_W'(1);
        end
        default: begin
          if (EX_branch_taken) begin
            ctrl      = CTRL_FLUSH;
            flush_evt = 1'b1;
          end else if (lu_hazard) begin
            ctrl = CTRL_LOAD;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LCNT_W'(LOAD_LAT - 1);
            end
          end
        end
      endcase
    end
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign PC_write      = ctrl.pc_write;
  assign IF_ID_write   = ctrl.if_id_write;
  assign IF_ID_flush   = ctrl.if_id_flush;
  assign ID_EX_write   = ctrl.id_ex_write;
  assign ID_EX_flush   = ctrl.id_ex_flush;
  assign EX_MEM_write  = ctrl.ex_mem_write;
  assign MEM_WB_bubble = ctrl.mem_wb_bubble;
  assign state         = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (!ctrl.pc_write),
    .clr_i   (perf_clr),
    .count_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (flush_evt),
    .clr_i   (perf_clr),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: one LOAD_LAT=1 instance with 2-bit counters (saturation)
// and one LOAD_LAT=3 instance, sharing all stimulus.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       uses1, uses2, memread, br, mreq, mrdy, pclr;

  logic       a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_bub;
  logic [1:0] a_stall, a_flush, a_state;
  logic       b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_bub;
  logic [31:0] b_stall, b_flush;
  logic [1:0] b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_uses_rs1(uses1), .ID_uses_rs2(uses2), .ID_EX_MemRead(memread),
    .ID_EX_rd(rd), .EX_branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .perf_clr(pclr), .PC_write(a_pcw), .IF_ID_write(a_ifw), .IF_ID_flush(a_iff),
    .ID_EX_write(a_idw), .ID_EX_flush(a_idf), .EX_MEM_write(a_exw),
    .MEM_WB_bubble(a_bub), .stall_cycles(a_stall), .flush_count(a_flush),
    .state(a_state)
  );

  hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_uses_rs1(uses1), .ID_uses_rs2(uses2), .ID_EX_MemRead(memread),
    .ID_EX_rd(rd), .EX_branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
    .perf_clr(pclr), .PC_write(b_pcw), .IF_ID_write(b_ifw), .IF_ID_flush(b_iff),
    .ID_EX_write(b_idw), .ID_EX_flush(b_idf), .EX_MEM_write(b_exw),
    .MEM_WB_bubble(b_bub), .stall_cycles(b_stall), .flush_count(b_flush),
    .state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard(input logic on);
    memread = on; rd = 5'd5; rs1 = 5'd5; uses1 = 1'b1; rs2 = 5'd0; uses2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0; rd = '0; uses1 = 0; uses2 = 0;
    memread = 0; br = 0; mreq = 0; mrdy = 0; pclr = 0;
    #3;
    chk("rst_pcw", 32'(a_pcw), 0);
    chk("rst_iff", 32'(b_iff), 1);
    chk("rst_idf", 32'(b_idf), 1);
    chk("rst_bub", 32'(b_bub), 1);
    chk("rst_exw", 32'(b_exw), 0);
    chk("rst_state", 32'(b_state), 0);
    chk("rst_stall", b_stall, 0);
    #9 rst_n = 1'b1;
    step();
    chk("idle_pcw", 32'(b_pcw), 1);
    chk("idle_idf", 32'(b_idf), 0);

    // Load-use hazard on rs1
    set_hazard(1'b1);
    #1;
    chk("lu1_pcw", 32'(a_pcw), 0);
    chk("lu1_ifw", 32'(a_ifw), 0);
    chk("lu1_idf", 32'(a_idf), 1);
    chk("lu1_exw", 32'(a_exw), 1);
    chk("lu3_pcw", 32'(b_pcw), 0);
    step();
    chk("lu1_state", 32'(a_state), 0);
    chk("lu1_stall", 32'(a_stall), 1);
    chk("lu3_state_a", 32'(b_state), 1);
    memread = 1'b0;
    #1;
    chk("lu1_release", 32'(a_pcw), 1);
    chk("lu3_still", 32'(b_pcw), 0);
    step();
    chk("lu3_state_b", 32'(b_state), 1);
    chk("lu3_stall_b", b_stall, 2);
    step();
    chk("lu3_state_c", 32'(b_state), 0);
    chk("lu3_stall", b_stall, 3);
    chk("lu3_pcw_run", 32'(b_pcw), 1);

    // Non-hazards: rd=x0, unused rs2 matching
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; uses1 = 1'b1;
    #1;
    chk("x0_pcw1", 32'(a_pcw), 1);
    chk("x0_pcw3", 32'(b_pcw), 1);
    rd = 5'd7; rs2 = 5'd7; uses2 = 1'b0; rs1 = 5'd3;
    #1;
    chk("rs2unused_pcw", 32'(a_pcw), 1);
    uses2 = 1'b1;
    #1;
    chk("rs2used_pcw", 32'(a_pcw), 0);
    uses2 = 1'b0;

    // Branch taken together with a load-use hazard
    set_hazard(1'b1);
    br = 1'b1;
    #1;
    chk("br_iff", 32'(b_iff), 1);
    chk("br_idf", 32'(b_idf), 1);
    chk("br_pcw", 32'(b_pcw), 1);
    chk("br_pcw1", 32'(a_pcw), 1);
    step();
    chk("br_flush1", 32'(a_flush), 1);
    chk("br_flush3", b_flush, 1);
    chk("br_stall3", b_stall, 3);
    chk("br_state3", 32'(b_state), 0);

    // Freeze during LOAD_STALL
    br = 1'b0;
    step();
    chk("fz_pre_state", 32'(b_state), 1);
    chk("fz_pre_stall", b_stall, 4);
    memread = 1'b0; mreq = 1'b1; mrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fz_pcw", 32'(b_pcw), 0);
      chk("fz_exw", 32'(b_exw), 0);
      chk("fz_idw", 32'(b_idw), 0);
      chk("fz_bub", 32'(b_bub), 1);
      step();
      chk("fz_state", 32'(b_state), 2);
    end
    chk("fz_stall3", b_stall, 8);
    chk("fz_sat1", 32'(a_stall), 3);
    mrdy = 1'b1;
    #1;
    chk("fzx_pcw", 32'(b_pcw), 0);
    chk("fzx_exw", 32'(b_exw), 1);
    chk("fzx_idf", 32'(b_idf), 1);
    chk("fzx_bub", 32'(b_bub), 0);
    chk("fzx_pcw1", 32'(a_pcw), 1);
    step();
    chk("fzx_state3", 32'(b_state), 1);
    chk("fzx_state1", 32'(a_state), 0);
    mreq = 1'b0; mrdy = 1'b0;
    step();
    chk("fzx_done", 32'(b_state), 0);
    chk("fzx_stall3", b_stall, 10);
    chk("fzx_sat1", 32'(a_stall), 3);

    // Reset pulsed mid-LOAD_STALL
    set_hazard(1'b1);
    step();
    chk("rs_pre", 32'(b_state), 1);
    memread = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_state", 32'(b_state), 0);
    chk("rs_stall", b_stall, 0);
    chk("rs_flush", b_flush, 0);
    chk("rs_stall1", 32'(a_stall), 0);
    chk("rs_iff", 32'(b_iff), 1);
    chk("rs_exw", 32'(b_exw), 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rs_after", 32'(b_state), 0);

    // perf_clr wins over increment; branch ignored in LOAD_STALL
    set_hazard(1'b1);
    step();
    chk("clr_pre1", 32'(a_stall), 1);
    chk("clr_pre3", b_stall, 1);
    pclr = 1'b1; br = 1'b1;
    #1;
    chk("ls_br_iff", 32'(b_iff), 0);
    chk("ls_br_pcw", 32'(b_pcw), 0);
    step();
    chk("clr_stall1", 32'(a_stall), 0);
    chk("clr_stall3", b_stall, 0);
    chk("clr_flush1", 32'(a_flush), 0);
    chk("clr_state3", 32'(b_state), 1);
    pclr = 1'b0; br = 1'b0; memread = 1'b0;
    step();
    chk("end_state3", 32'(b_state), 0);
    chk("end_stall3", b_stall, 1);
    chk("end_stall1", 32'(a_stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage RISC-V core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
- load-use hazards, with a configurable number of bubble cycles;
- taken-branch flushes, resolved in EX;
- data-memory wait states, which freeze the whole pipeline.

It drives the pipeline-register write enables and flushes, and keeps saturating stall and flush performance counters.

Parameters:
LOAD_LAT, 1, load-use bubble cycles inserted per hazard; legal range 1..4.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  core clock.
rst_n  input  1  asynchronous active-low reset.
IF_ID_rs1  input  5  rs1 field of the instruction in ID.
IF_ID_rs2  input  5  rs2 field of the instruction in ID.
ID_uses_rs1  input  1  ID instruction reads rs1.
ID_uses_rs2  input  1  ID instruction reads rs2.
ID_EX_MemRead  input  1  instruction in EX is a load.
ID_EX_rd  input  5  destination register of the instruction in EX.
EX_branch_taken  input  1  branch/jump in EX redirects the PC.
mem_req  input  1  MEM stage performs a data-memory access this cycle.
mem_ready  input  1  data memory completes the access this cycle.
perf_clr  input  1  synchronous clear of both counters.
PC_write  output  1  PC register enable.
IF_ID_write  output  1  IF/ID register enable.
IF_ID_flush  output  1  IF/ID loads a NOP.
ID_EX_write  output  1  ID/EX register enable.
ID_EX_flush  output  1  ID/EX loads a bubble (all control signals 0).
EX_MEM_write  output  1  EX/MEM register enable.
MEM_WB_bubble  output  1  MEM/WB loads a bubble (RegWrite=0).
stall_cycles  output  CNT_W  cycles with PC_write=0, saturating.
flush_count  output  CNT_W  taken-branch flush events, saturating.
state  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, load counter=0, saved state=RUN.
  - Both perf counters=0.
  - While rst_n is low: all write enables=0, IF_ID_flush=ID_EX_flush=MEM_WB_bubble=1.
  - Reset asserted mid-stall aborts the stall immediately.
- Control outputs are combinational from state and inputs. State and counters update on the rising clk edge.
- Default (no hazard): all write enables=1, all flush/bubble=0.
- Derived conditions:
  - freeze = mem_req && !mem_ready.
  - lu_hazard = ID_EX_MemRead && ID_EX_rd!=0 && ((ID_uses_rs1 && ID_EX_rd==IF_ID_rs1) || (ID_uses_rs2 && ID_EX_rd==IF_ID_rs2)).
- Priority: freeze > EX_branch_taken > lu_hazard.
- Freeze response, in any state:
  - PC_write, IF_ID_write, ID_EX_write, EX_MEM_write = 0; MEM_WB_bubble=1.
  - Enter MEM_WAIT and save the return state; the load counter holds.
  - A pending branch or load hazard is held stable by the frozen registers and is serviced after the freeze ends.
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- RUN, branch taken (no freeze):
  - IF_ID_flush=1, ID_EX_flush=1, PC_write=1.
  - flush_count increments. Takes one cycle and stays in RUN.
  - A simultaneous lu_hazard is ignored, because the ID instruction is wrong-path.
- RUN, lu_hazard (no freeze, no branch):
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1; EX_MEM_write stays 1 so the load advances.
  - LOAD_LAT=1: stay in RUN. The next cycle has a bubble in EX, so no re-detection.
  - LOAD_LAT>1: go to LOAD_STALL with cnt=LOAD_LAT-1.
- LOAD_STALL:
  - Same outputs as the RUN lu_hazard case.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - EX_branch_taken cannot occur here because EX holds a bubble; if it is asserted anyway, it is ignored.
- MEM_WAIT:
  - Outputs as for freeze while freeze persists.
  - On the first cycle with !freeze, return to the saved state. Outputs that cycle are evaluated as in the saved state.
- stall_cycles: increments every post-reset cycle with PC_write=0; saturates at all-ones.
- flush_count: saturates at all-ones.
- perf_clr: clears both counters; it takes priority over an increment in the same cycle.

Decomposition:
- Shared package (hazard_pkg): state enum {RUN, LOAD_STALL, MEM_WAIT}, a REG_X0 constant, and a control-output struct.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Load x5 in EX, ID reads rs1=x5, LOAD_LAT=1 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles=1.
- Same hazard with LOAD_LAT=3 -> 3 consecutive stall cycles; state sequence RUN, LOAD_STALL, LOAD_STALL, RUN; stall_cycles=3.
- Load with rd=x0 matching rs1=0, or ID_uses_rs2=0 with rs2 matching -> no stall.
- EX_branch_taken together with lu_hazard -> IF_ID_flush=ID_EX_flush=1, PC_write=1; flush_count=1; no stall.
- mem_req=1 with mem_ready low for 4 cycles during LOAD_STALL (cnt=2) -> 4 cycles in MEM_WAIT with all enables 0 and MEM_WB_bubble=1; then return to LOAD_STALL with cnt still 2; stall_cycles grows by 4 plus the remaining stall cycles.
- rst_n pulsed low mid-LOAD_STALL -> state=RUN and both counters=0 immediately; perf_clr together with an increment -> counter=0.
